mem_port_arbiter: RTL and testbench

- Shares one single-port, request/acknowledge memory between the pipelined CPU's instruction-fetch port and data port.
- Sits between the cpu instance and the memory/bus subsystem.
- For each CPU pipeline advance, it serialises the data access first, then the instruction fetch.
- It holds the CPU stalled until both accesses complete, and presents the registered read results to the CPU.

---
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Serialises the CPU data access and instruction fetch onto one request/acknowledge memory port.
// The CPU is held stalled until both accesses of a pipeline advance have completed or timed out.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_DATA | issue the data access if drw|dre, otherwise pass straight on
// S_INST | fetch the instruction at iaddr
// S_DONE | release stall for one cycle so the pipeline advances
module mem_port_arbiter #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iaddr,
    output logic [31:0] iin,
    input  logic [31:0] daddr,
    input  logic [31:0] dout,
    input  logic        drw,
    input  logic        dre,
    output logic [31:0] din,
    output logic        stall,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_we,
    output logic        m_req,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        S_DATA = 2'd0,
        S_INST = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state;
    logic [TO_W-1:0] cnt;
    logic            data_req;
    logic            timed_out;
    logic            finish;

    assign data_req = drw | dre;

    // The request is decoded from the registered state so an ack can land in the
    // first cycle; rst gates it so the bus is released the instant reset asserts.
    assign m_req   = rst && ((state == S_DATA && data_req) || state == S_INST);
    assign m_we    = rst && state == S_DATA && drw;
    assign m_addr  = (state == S_INST) ? iaddr : daddr;
    assign m_wdata = dout;
    assign stall   = (state != S_DONE);

    // Abort fires on the cycle the counter would reach TIMEOUT; an ack in that cycle wins.
    assign timed_out = m_req && !m_ack && (cnt == TO_LAST);
    assign finish    = (m_req && m_ack) || timed_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_DATA;
            cnt   <= '0;
            iin   <= '0;
            din   <= '0;
            err   <= 1'b0;
        end else begin
            if (timed_out) begin
                err <= 1'b1;
            end
            case (state)
                S_DATA: begin
                    if (!data_req) begin
                        state <= S_INST;
                        cnt   <= '0;
                    end else if (finish) begin
                        if (!drw) begin
                            din <= timed_out ? 32'd0 : m_rdata;
                        end
                        state <= S_INST;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + TO_W'(1);
                    end
                end
                S_INST: begin
                    if (finish) begin
                        iin   <= timed_out ? 32'd0 : m_rdata;
                        state <= S_DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + TO_W'(1);
                    end
                end
                default: begin
                    state <= S_DATA;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single-ack CPU advances on a
// TIMEOUT=255 instance plus hand sequences for slow acks, timeout and reset on a TIMEOUT=3 instance.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iaddr, daddr, dout;
    logic        drw, dre;
    logic [31:0] cur_inst, cur_data;

    logic        ack_a, ack_b;
    logic [31:0] iin_a, din_a, m_addr_a, m_wdata_a, rdata_a;
    logic        stall_a, m_we_a, m_req_a, err_a;
    logic [31:0] iin_b, din_b, m_addr_b, m_wdata_b, rdata_b;
    logic        stall_b, m_we_b, m_req_b, err_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Simple memory: instruction word when the bus carries iaddr, data word otherwise.
    assign rdata_a = (m_addr_a == iaddr) ? cur_inst : cur_data;
    assign rdata_b = (m_addr_b == iaddr) ? cur_inst : cur_data;

    mem_port_arbiter u_dut (
        .clk(clk), .rst(rst), .iaddr(iaddr), .iin(iin_a), .daddr(daddr), .dout(dout),
        .drw(drw), .dre(dre), .din(din_a), .stall(stall_a), .m_addr(m_addr_a),
        .m_wdata(m_wdata_a), .m_we(m_we_a), .m_req(m_req_a), .m_ack(ack_a),
        .m_rdata(rdata_a), .err(err_a)
    );

    mem_port_arbiter #(.TO_W(8), .TIMEOUT(3)) u_dut_to (
        .clk(clk), .rst(rst), .iaddr(iaddr), .iin(iin_b), .daddr(daddr), .dout(dout),
        .drw(drw), .dre(dre), .din(din_b), .stall(stall_b), .m_addr(m_addr_b),
        .m_wdata(m_wdata_b), .m_we(m_we_b), .m_req(m_req_b), .m_ack(ack_b),
        .m_rdata(rdata_b), .err(err_b)
    );

    typedef struct {
        logic        drw;
        logic        dre;
        logic [31:0] daddr;
        logic [31:0] dout;
        logic [31:0] iaddr;
        logic [31:0] data;
        logic [31:0] inst;
        logic        exp_req;
        logic        exp_we;
        logic [31:0] exp_din;
        logic [31:0] exp_iin;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called while u_dut sits in S_DATA before its evaluating edge.
    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        drw = v.drw; dre = v.dre; daddr = v.daddr; dout = v.dout; iaddr = v.iaddr;
        cur_data = v.data; cur_inst = v.inst; ack_a = 1'b1;
        #1;
        chk($sformatf("v%0d m_req data phase", idx), 32'(m_req_a), 32'(v.exp_req));
        chk($sformatf("v%0d m_we data phase", idx), 32'(m_we_a), 32'(v.exp_we));
        if (v.exp_req) begin
            chk($sformatf("v%0d m_addr data phase", idx), m_addr_a, v.daddr);
            chk($sformatf("v%0d m_wdata data phase", idx), m_wdata_a, v.dout);
        end
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                chk($sformatf("v%0d m_addr fetch", idx), m_addr_a, v.iaddr);
                chk($sformatf("v%0d m_we fetch", idx), 32'(m_we_a), 32'd0);
            end
        end while (stall_a && cyc < 10);
        chk($sformatf("v%0d edges to stall low", idx), cyc, 2);
        @(posedge clk); #1;
        chk($sformatf("v%0d stall back high", idx), 32'(stall_a), 32'd1);
        chk($sformatf("v%0d din", idx), din_a, v.exp_din);
        chk($sformatf("v%0d iin", idx), iin_a, v.exp_iin);
    endtask

    // Called on u_dut_to's first S_INST cycle; ack_b rises on request cycle ack_at.
    task automatic inst_b(input int ack_at, output int req_cycles);
        int guard;
        req_cycles = 0;
        guard = 0;
        while (stall_b && guard < 10) begin
            ack_b = (req_cycles == ack_at);
            if (m_req_b) req_cycles++;
            @(posedge clk); #1;
            guard++;
        end
        ack_b = 1'b0;
    endtask

    initial begin
        int rc;
        vecs[0] = '{1'b0, 1'b0, 32'h1000_0000, 32'h0, 32'h0000_0010, 32'hFFFF_0000,
                    32'h8C82_0004, 1'b0, 1'b0, 32'h0, 32'h8C82_0004};
        vecs[1] = '{1'b0, 1'b1, 32'h1000_0004, 32'h0, 32'h0000_0014, 32'hDEAD_BEEF,
                    32'h0022_1820, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0022_1820};
        vecs[2] = '{1'b1, 1'b0, 32'h1000_0008, 32'h1234_5678, 32'h0000_0018, 32'h3333_3333,
                    32'hAC43_0000, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hAC43_0000};
        vecs[3] = '{1'b1, 1'b1, 32'h1000_000C, 32'hCAFE_F00D, 32'h0000_001C, 32'h1111_1111,
                    32'h0000_0020, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0020};
        vecs[4] = '{1'b0, 1'b1, 32'h2000_0000, 32'h0, 32'h0000_0020, 32'h0BAD_CAFE,
                    32'h0000_0024, 1'b1, 1'b0, 32'h0BAD_CAFE, 32'h0000_0024};

        rst = 1'b0; drw = 1'b0; dre = 1'b1; daddr = 32'h0; dout = 32'h0; iaddr = 32'h0;
        cur_inst = 32'h0; cur_data = 32'h0; ack_a = 1'b1; ack_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", 32'(stall_a), 32'd1);
        chk("reset m_req", 32'(m_req_a), 32'd0);
        chk("reset iin", iin_a, 32'd0);
        chk("reset din", din_a, 32'd0);
        chk("reset err", 32'(err_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Write held for four cycles without ack, acked on the fifth.
        drw = 1'b1; dre = 1'b0; daddr = 32'h1000_0008; dout = 32'h1234_5678;
        iaddr = 32'h0000_0030; cur_inst = 32'h0123_4567; cur_data = 32'h5555_5555; ack_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("slow wr c%0d m_req", i), 32'(m_req_a), 32'd1);
            chk($sformatf("slow wr c%0d m_we", i), 32'(m_we_a), 32'd1);
            chk($sformatf("slow wr c%0d m_addr", i), m_addr_a, 32'h1000_0008);
            chk($sformatf("slow wr c%0d m_wdata", i), m_wdata_a, 32'h1234_5678);
            if (i == 4) ack_a = 1'b1;
            @(posedge clk);
        end
        #1;
        chk("slow wr fetch m_addr", m_addr_a, 32'h0000_0030);
        chk("slow wr fetch m_we", 32'(m_we_a), 32'd0);
        chk("slow wr fetch m_req", 32'(m_req_a), 32'd1);
        chk("slow wr din kept", din_a, 32'h0BAD_CAFE);
        drw = 1'b0;
        @(posedge clk); #1;
        chk("slow wr stall low", 32'(stall_a), 32'd0);
        chk("slow wr iin", iin_a, 32'h0123_4567);

        // Timeout instance sequences.
        rst = 1'b0; ack_b = 1'b1; iaddr = 32'h0000_0040; cur_inst = 32'h0000_AAAA;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        inst_b(0, rc);
        chk("to first fetch req cycles", rc, 1);
        chk("to first fetch iin", iin_b, 32'h0000_AAAA);
        @(posedge clk); #1;
        iaddr = 32'h0000_0044; cur_inst = 32'h0000_BBBB;
        @(posedge clk); #1;
        inst_b(2, rc);
        chk("ack at limit req cycles", rc, 3);
        chk("ack at limit iin", iin_b, 32'h0000_BBBB);
        chk("ack at limit err", 32'(err_b), 32'd0);
        @(posedge clk); #1;
        iaddr = 32'h0000_0048;
        @(posedge clk); #1;
        inst_b(99, rc);
        chk("timeout req cycles", rc, 3);
        chk("timeout stall low", 32'(stall_b), 32'd0);
        chk("timeout m_req dropped", 32'(m_req_b), 32'd0);
        chk("timeout iin zero", iin_b, 32'd0);
        chk("timeout err", 32'(err_b), 32'd1);
        @(posedge clk); #1;
        chk("timeout stall one cycle", 32'(stall_b), 32'd1);
        dre = 1'b1; daddr = 32'h1000_0010; cur_data = 32'h7777_7777;
        iaddr = 32'h0000_004C; cur_inst = 32'h0000_CCCC; ack_b = 1'b1;
        #1;
        chk("after timeout data req", 32'(m_req_b), 32'd1);
        @(posedge clk); #1;
        dre = 1'b0;
        inst_b(0, rc);
        chk("after timeout din", din_b, 32'h7777_7777);
        chk("after timeout iin", iin_b, 32'h0000_CCCC);
        chk("err sticky", 32'(err_b), 32'd1);

        // Reset asserted mid-fetch.
        @(posedge clk); #1;
        iaddr = 32'h0000_0050;
        @(posedge clk); #1;
        ack_b = 1'b0;
        @(posedge clk); #1;
        chk("mid fetch m_req", 32'(m_req_b), 32'd1);
        rst = 1'b0;
        #1;
        chk("async rst m_req", 32'(m_req_b), 32'd0);
        chk("async rst stall", 32'(stall_b), 32'd1);
        chk("async rst iin", iin_b, 32'd0);
        chk("async rst err", 32'(err_b), 32'd0);
        chk("async rst din", din_b, 32'd0);
        chk("async rst main m_req", 32'(m_req_a), 32'd0);
        chk("async rst main iin", iin_a, 32'd0);
        chk("async rst main din", din_a, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
